// File: rtl/char_pkg.sv
// char_pkg: key codes, character classes and parser states shared by the line parser.
package char_pkg;
   localparam logic [6:0] KEY_ENTER   = 7'h04;
   localparam logic [6:0] KEY_DELETE  = 7'h08;
   localparam logic [6:0] KEY_COMMA   = 7'h7E;
   localparam logic [6:0] KEY_ENE_LO  = 7'h6E;
   localparam logic [6:0] KEY_ENE_UP  = 7'h4E;
   localparam logic [6:0] KEY_DIGIT_0 = 7'h30;
   localparam logic [6:0] KEY_DIGIT_9 = 7'h39;
   typedef enum logic [2:0] {CLS_ENTER, CLS_DELETE, CLS_COMMA, CLS_ENE, CLS_DIGIT, CLS_OTHER} char_class_t;
   typedef enum logic [1:0] {S_TEXT, S_NUM, S_DONE} state_t;
endpackage

// File: rtl/char_classify.sv
// char_classify: combinational key code -> character class decoder.
//   code_i : key code
//   cls_o  : class of code_i
module char_classify
   import char_pkg::*;
#(
   parameter int CHAR_W = 7
) (
   input  logic [CHAR_W-1:0] code_i,
   output char_class_t       cls_o
);
   logic is_digit;
   assign is_digit = code_i >= CHAR_W'(KEY_DIGIT_0) && code_i <= CHAR_W'(KEY_DIGIT_9);
   always_comb
      cls_o = code_i == CHAR_W'(KEY_ENTER)  ? CLS_ENTER  :
              code_i == CHAR_W'(KEY_DELETE) ? CLS_DELETE :
              code_i == CHAR_W'(KEY_COMMA)  ? CLS_COMMA  :
              (code_i == CHAR_W'(KEY_ENE_LO) || code_i == CHAR_W'(KEY_ENE_UP)) ? CLS_ENE :
              is_digit ? CLS_DIGIT : CLS_OTHER;
endmodule

// File: rtl/char_line_parser.sv
// char_line_parser: stores typed text in a line buffer, then parses comma-separated decimal fields.
//   clk, rst_n         : clock, asynchronous active-low reset
//   char_valid_i/char_i: key code stream, accepted when char_ready_o is high
//   char_ready_o       : low only once the line is complete
//   clear_i            : abandon the line and return to text entry (beats a simultaneous key)
//   rd_addr_i/rd_char_o: combinational text buffer read port
//   line_len_o         : number of stored text characters
//   num_out_o          : parsed fields, field 0 in the LSBs
//   num_count_o        : number of committed fields
//   line_done_o        : line complete, outputs frozen until clear_i
//   err_full_o         : sticky, a text character was dropped on a full buffer
//   err_sat_o          : sticky, a field saturated or an excess comma was seen
// Build option CHAR_LINE_PARSER_ENE_MAP_EN: store n/N in text as ENE_CODE instead of verbatim.
module char_line_parser
   import char_pkg::*;
#(
   parameter int CHAR_W     = 7,
   parameter int DEPTH      = 16,
   parameter int NUM_W      = 8,
   parameter int NUM_FIELDS = 4,
   parameter logic [CHAR_W-1:0] ENE_CODE = CHAR_W'(7'h7F)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           char_valid_i,
   input  logic [CHAR_W-1:0]              char_i,
   output logic                           char_ready_o,
   input  logic                           clear_i,
   input  logic [$clog2(DEPTH)-1:0]       rd_addr_i,
   output logic [CHAR_W-1:0]              rd_char_o,
   output logic [$clog2(DEPTH):0]         line_len_o,
   output logic [NUM_FIELDS*NUM_W-1:0]    num_out_o,
   output logic [$clog2(NUM_FIELDS):0]    num_count_o,
   output logic                           line_done_o,
   output logic                           err_full_o,
   output logic                           err_sat_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(NUM_FIELDS);
   localparam int DW = 8;
`ifdef CHAR_LINE_PARSER_ENE_MAP_EN
   localparam bit ENE_MAP = 1'b1;
`else
   localparam bit ENE_MAP = 1'b0;
`endif
   state_t                        state_q, state_d;
   logic [AW:0]                   len_q, len_d;
   logic [FW-1:0]                 idx_q, idx_d;
   logic [FW:0]                   cnt_q, cnt_d;
   logic [NUM_FIELDS*NUM_W-1:0]   nums_q, nums_d;
   logic [NUM_W-1:0]              acc_q, acc_d;
   logic [DW-1:0]                 dig_q, dig_d;
   logic                          err_full_q, err_full_d;
   logic                          err_sat_q, err_sat_d;
   logic                          done_q, done_d;
   logic [CHAR_W-1:0]             buf_q [DEPTH];
   logic [CHAR_W-1:0]             wr_code;
   logic                          wr_en;
   logic                          take;
   logic [NUM_W+3:0]              prod;
   logic                          sat;
   char_class_t                   cls;
   char_classify #(.CHAR_W(CHAR_W)) u_cls (.code_i(char_i), .cls_o(cls));
   assign take    = char_valid_i && !done_q;
   assign wr_code = (ENE_MAP && cls == CLS_ENE) ? ENE_CODE : char_i;
   // NUM_W+4 bits hold acc*10+9 for any acc, so saturation is a simple compare
   assign prod = (NUM_W+4)'(acc_q) * (NUM_W+4)'(10) + (NUM_W+4)'(char_i[3:0]);
   assign sat  = prod > (NUM_W+4)'({NUM_W{1'b1}});
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      nums_d     = nums_q;
      acc_d      = acc_q;
      dig_d      = dig_q;
      err_full_d = err_full_q;
      err_sat_d  = err_sat_q;
      done_d     = done_q;
      wr_en      = 1'b0;
      if (clear_i) begin
         state_d    = S_TEXT;
         len_d      = '0;
         idx_d      = '0;
         cnt_d      = '0;
         nums_d     = '0;
         acc_d      = '0;
         dig_d      = '0;
         err_full_d = 1'b0;
         err_sat_d  = 1'b0;
         done_d     = 1'b0;
      end else if (take) begin
         case (state_q)
            S_TEXT: begin
               if (cls == CLS_ENTER) begin
                  state_d = S_NUM;
                  idx_d   = '0;
               end else if (cls == CLS_DELETE) begin
                  len_d = len_q - {{AW{1'b0}}, |len_q};
               end else if (len_q == (AW+1)'(DEPTH)) begin
                  err_full_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  len_d = len_q + 1'b1;
               end
            end
            S_NUM: begin
               case (cls)
                  CLS_DIGIT: begin
                     acc_d     = sat ? '1 : prod[NUM_W-1:0];
                     err_sat_d = err_sat_q | sat;
                     dig_d     = dig_q + {{DW-1{1'b0}}, ~&dig_q};
                  end
                  CLS_DELETE: begin
                     if (dig_q != '0) begin
                        acc_d = acc_q / NUM_W'(10);
                        dig_d = dig_q - 1'b1;
                     end
                  end
                  CLS_COMMA: begin
                     if (idx_q == FW'(NUM_FIELDS-1)) begin
                        err_sat_d = 1'b1;
                     end else begin
                        nums_d[idx_q*NUM_W +: NUM_W] = acc_q;
                        idx_d = idx_q + 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        acc_d = '0;
                        dig_d = '0;
                     end
                  end
                  CLS_ENTER: begin
                     nums_d[idx_q*NUM_W +: NUM_W] = acc_q;
                     cnt_d   = cnt_q + 1'b1;
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_TEXT;
         len_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         nums_q     <= '0;
         acc_q      <= '0;
         dig_q      <= '0;
         err_full_q <= 1'b0;
         err_sat_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         nums_q     <= nums_d;
         acc_q      <= acc_d;
         dig_q      <= dig_d;
         err_full_q <= err_full_d;
         err_sat_q  <= err_sat_d;
         done_q     <= done_d;
      end
   end
   // Buffer contents need no reset: only entries below line_len are meaningful
   always_ff @(posedge clk)
      if (wr_en) buf_q[len_q[AW-1:0]] <= wr_code;
   assign rd_char_o    = buf_q[rd_addr_i];
   assign char_ready_o = !done_q;
   assign line_len_o   = len_q;
   assign num_out_o    = nums_q;
   assign num_count_o  = cnt_q;
   assign line_done_o  = done_q;
   assign err_full_o   = err_full_q;
   assign err_sat_o    = err_sat_q;
endmodule

// File: tb/tb_char_line_parser.sv
// tb_char_line_parser: scoreboard bench for char_line_parser against a queue-based line model.
module tb_char_line_parser;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        char_valid_i = 1'b0;
   logic [6:0]  char_i = '0;
   logic        char_ready_o;
   logic        clear_i = 1'b0;
   logic [3:0]  rd_addr_i = '0;
   logic [6:0]  rd_char_o;
   logic [4:0]  line_len_o;
   logic [31:0] num_out_o;
   logic [2:0]  num_count_o;
   logic        line_done_o;
   logic        err_full_o;
   logic        err_sat_o;
   always #5 clk = ~clk;
   char_line_parser dut (
      .clk(clk), .rst_n(rst_n), .char_valid_i(char_valid_i), .char_i(char_i),
      .char_ready_o(char_ready_o), .clear_i(clear_i), .rd_addr_i(rd_addr_i),
      .rd_char_o(rd_char_o), .line_len_o(line_len_o), .num_out_o(num_out_o),
      .num_count_o(num_count_o), .line_done_o(line_done_o),
      .err_full_o(err_full_o), .err_sat_o(err_sat_o)
   );
   typedef struct {
      int len; int cnt; logic [31:0] nums; bit done; bit ef; bit es; bit rd_chk; logic [6:0] rdc;
   } snap_t;
   snap_t sbq[$];
   int n_tests = 0;
   int n_fail  = 0;
   // reference model: mode 0 text, 1 numbers, 2 done
   int         mode;
   logic [6:0] text[$];
   int         fields[4];
   int         nf, acc, dig;
   bit         ef, es;
   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [6:0] stored(input logic [6:0] c);
`ifdef CHAR_LINE_PARSER_ENE_MAP_EN
      return (c == 7'h6E || c == 7'h4E) ? 7'h7F : c;
`else
      return c;
`endif
   endfunction
   function automatic void m_clear();
      mode = 0; text.delete();
      for (int i = 0; i < 4; i++) fields[i] = 0;
      nf = 0; acc = 0; dig = 0; ef = 0; es = 0;
   endfunction
   function automatic void m_char(input logic [6:0] c);
      bit digit;
      digit = c >= 7'h30 && c <= 7'h39;
      if (mode == 0) begin
         if (c == 7'h04) mode = 1;
         else if (c == 7'h08) begin
            if (text.size() > 0) void'(text.pop_back());
         end else if (text.size() == 16) ef = 1;
         else text.push_back(stored(c));
      end else if (mode == 1) begin
         if (digit) begin
            acc = acc * 10 + (int'(c) - 48);
            if (acc > 255) begin acc = 255; es = 1; end
            dig++;
         end else if (c == 7'h08) begin
            if (dig > 0) begin acc = acc / 10; dig--; end
         end else if (c == 7'h7E) begin
            if (nf < 3) begin fields[nf] = acc; nf++; acc = 0; dig = 0; end
            else es = 1;
         end else if (c == 7'h04) begin
            fields[nf] = acc; nf++; mode = 2;
         end
      end
   endfunction
   function automatic void push(input int a);
      snap_t s;
      s.len = text.size(); s.cnt = nf; s.done = mode == 2; s.ef = ef; s.es = es;
      s.nums = '0;
      for (int i = 0; i < 4; i++) s.nums[i*8 +: 8] = 8'(fields[i]);
      s.rd_chk = a < text.size();
      s.rdc = s.rd_chk ? text[a] : 7'h0;
      sbq.push_back(s);
   endfunction
   always @(negedge clk) begin
      snap_t e;
      if (rst_n && sbq.size() != 0) begin
         e = sbq.pop_front();
         check("line_len", int'(line_len_o), e.len);
         check("num_count", int'(num_count_o), e.cnt);
         check("num_out", int'(num_out_o), int'(e.nums));
         check("line_done", int'(line_done_o), int'(e.done));
         check("char_ready", int'(char_ready_o), int'(!e.done));
         check("err_full", int'(err_full_o), int'(e.ef));
         check("err_sat", int'(err_sat_o), int'(e.es));
         if (e.rd_chk) check("rd_char", int'(rd_char_o), int'(e.rdc));
      end
   end
   task automatic cyc(input logic v, input logic [6:0] c, input logic clr, input int a);
      char_valid_i = v; char_i = c; clear_i = clr; rd_addr_i = 4'(a);
      @(posedge clk);
      if (clr) m_clear();
      else if (v && mode != 2) m_char(c);
      push(a);
      @(negedge clk);
      #1;
      char_valid_i = 1'b0; clear_i = 1'b0;
   endtask
   task automatic key(input logic [6:0] c);
      cyc(1'b1, c, 1'b0, int'($urandom_range(0, 15)));
   endtask
   task automatic type_str(input string s);
      for (int i = 0; i < s.len(); i++) key(7'(s[i]));
   endtask
   task automatic sweep();
      for (int i = 0; i < 16; i++) cyc(1'b0, 7'h0, 1'b0, i);
   endtask
   task automatic clr();
      cyc(1'b0, 7'h0, 1'b1, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      int r;
      logic [6:0] c;
      m_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      cyc(1'b0, 7'h0, 1'b0, 0);
      // basic line
      type_str("HOLA"); key(7'h04); type_str("12~34"); key(7'h04);
      sweep(); key(7'h37); key(7'h04); clr();
      // full buffer then delete underflow
      type_str("ABCDEFGHIJKLMNOPQ"); sweep();
      repeat (20) key(7'h08);
      clr();
      // saturation and delete in a field
      key(7'h04); type_str("256"); key(7'h04); clr();
      key(7'h04); type_str("123"); key(7'h08); key(7'h04); clr();
      // excess fields
      key(7'h04); type_str("1~2~3~4~5"); key(7'h04); clr();
      // clear beats a simultaneous Enter
      key(7'h04); type_str("7"); cyc(1'b1, 7'h04, 1'b1, 0); type_str("A"); sweep(); clr();
      // Ene in text
      type_str("nN"); sweep(); clr();
      // asynchronous reset mid-line
      type_str("AB"); key(7'h04); type_str("9~8");
      #2 rst_n = 1'b0;
      #1;
      check("rst line_len", int'(line_len_o), 0);
      check("rst num_count", int'(num_count_o), 0);
      check("rst num_out", int'(num_out_o), 0);
      check("rst line_done", int'(line_done_o), 0);
      check("rst err", int'({err_full_o, err_sat_o}), 0);
      check("rst char_ready", int'(char_ready_o), 1);
      m_clear();
      @(negedge clk);
      #1 rst_n = 1'b1;
      cyc(1'b0, 7'h0, 1'b0, 0);
      // random traffic
      for (int n = 0; n < 1500; n++) begin
         r = int'($urandom_range(0, 99));
         c = r < 35 ? 7'(7'h30 + $urandom_range(0, 9)) :
             r < 45 ? 7'h7E :
             r < 55 ? 7'h08 :
             r < 62 ? 7'h04 :
             r < 67 ? (($urandom_range(0, 1) != 0) ? 7'h6E : 7'h4E) :
             r < 90 ? 7'(7'h41 + $urandom_range(0, 25)) : 7'($urandom_range(0, 127));
         cyc(1'($urandom_range(0, 99) < 85), c,
             1'((mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0),
             int'($urandom_range(0, 15)));
      end
      repeat (4) @(negedge clk);
      if (sbq.size() != 0) check("scoreboard drain", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
